// File: rtl/mem_narrow_to_wide_adapter_pkg.sv
// Shared types and helpers for the 4-byte core port to 16-byte line memory adapter.
package mem_narrow_to_wide_adapter_pkg;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned OFF_BITS   = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OPAQUE_W   = 8;
    localparam int unsigned TYPE_W     = 3;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_W     = LINE_BYTES * 8;

    localparam logic [TYPE_W-1:0] MEM_TYPE_READ  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] MEM_TYPE_WRITE = TYPE_W'(1);

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [ADDR_W-1:0]   addr;
        logic [1:0]          len;
        logic [WORD_W-1:0]   data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [1:0]          test;
        logic [1:0]          len;
        logic [WORD_W-1:0]   data;
    } mem_resp_4B_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [ADDR_W-1:0]   addr;
        logic [3:0]          len;
        logic [LINE_W-1:0]   data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   type_;
        logic [OPAQUE_W-1:0] opaque;
        logic [1:0]          test;
        logic [3:0]          len;
        logic [LINE_W-1:0]   data;
    } mem_resp_16B_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RESP
    } adapter_state_e;

    // len encodes 1 or 2 bytes directly; 0 (and the unused 3) mean a full word.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        case (len)
            2'd1:    return 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/line_byte_merge.sv
// Byte-lane steering between a 16-byte line and a 4-byte word; lanes past the line end are dropped.
module line_byte_merge
    import mem_narrow_to_wide_adapter_pkg::*;
(
    input  logic [LINE_W-1:0]   line,
    input  logic [WORD_W-1:0]   word,
    input  logic [OFF_BITS-1:0] off,
    input  logic [2:0]          nbytes,
    output logic [LINE_W-1:0]   merged_line_c,
    output logic [WORD_W-1:0]   extract_word_c
);

    logic [OFF_BITS:0] idx;

    always_comb begin
        merged_line_c  = line;
        extract_word_c = '0;
        idx            = '0;
        for (int j = 0; j < 4; j++) begin
            idx = (OFF_BITS + 1)'(off) + (OFF_BITS + 1)'(j);
            if ((3'(j) < nbytes) && (idx < (OFF_BITS + 1)'(LINE_BYTES))) begin
                merged_line_c[{idx[OFF_BITS-1:0], 3'b000} +: 8] = word[8*j +: 8];
                extract_word_c[8*j +: 8] = line[{idx[OFF_BITS-1:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_narrow_to_wide_adapter.sv
// Converts 4-byte core requests into 16-byte line requests; sub-line writes use read-modify-write.
module mem_narrow_to_wide_adapter
    import mem_narrow_to_wide_adapter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  mem_req_4B_t   creq_msg,
    input  logic          creq_val,
    output logic          creq_rdy,
    output mem_resp_4B_t  cresp_msg,
    output logic          cresp_val,
    input  logic          cresp_rdy,
    output mem_req_16B_t  mreq_msg,
    output logic          mreq_val,
    input  logic          mreq_rdy,
    input  mem_resp_16B_t mresp_msg,
    input  logic          mresp_val,
    output logic          mresp_rdy
);

    adapter_state_e state_q, state_d;
    mem_req_4B_t    req_q, req_d;
    mem_req_16B_t   mreq_q, mreq_d;
    mem_resp_4B_t   cresp_q, cresp_d;
    logic           creq_rdy_q, creq_rdy_d;
    logic           mreq_val_q, mreq_val_d;
    logic           mresp_rdy_q, mresp_rdy_d;
    logic           cresp_val_q, cresp_val_d;

    logic [LINE_W-1:0] merged_line_c;
    logic [WORD_W-1:0] extract_word_c;
    logic              unused_mresp_c;

    // Write-response payload carries nothing we need.
    assign unused_mresp_c = ^{mresp_msg.type_, mresp_msg.opaque, mresp_msg.test, mresp_msg.len};

    line_byte_merge u_merge (
        .line           (mresp_msg.data),
        .word           (req_q.data),
        .off            (req_q.addr[OFF_BITS-1:0]),
        .nbytes         (len_to_nbytes(req_q.len)),
        .merged_line_c  (merged_line_c),
        .extract_word_c (extract_word_c)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        mreq_d  = mreq_q;
        cresp_d = cresp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (creq_val && creq_rdy_q) begin
                    req_d        = creq_msg;
                    mreq_d       = '0;
                    mreq_d.type_ = MEM_TYPE_READ;
                    mreq_d.addr  = line_base(creq_msg.addr);
                    state_d      = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (mreq_val_q && mreq_rdy) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mresp_val && mresp_rdy_q) begin
                    if (req_q.type_ == MEM_TYPE_WRITE) begin
                        mreq_d       = '0;
                        mreq_d.type_ = MEM_TYPE_WRITE;
                        mreq_d.addr  = line_base(req_q.addr);
                        mreq_d.data  = merged_line_c;
                        state_d      = ST_WR_REQ;
                    end else begin
                        cresp_d        = '0;
                        cresp_d.type_  = req_q.type_;
                        cresp_d.opaque = req_q.opaque;
                        cresp_d.len    = req_q.len;
                        cresp_d.data   = extract_word_c;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_WR_REQ: begin
                if (mreq_val_q && mreq_rdy) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mresp_val && mresp_rdy_q) begin
                    cresp_d        = '0;
                    cresp_d.type_  = req_q.type_;
                    cresp_d.opaque = req_q.opaque;
                    cresp_d.len    = req_q.len;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cresp_val_q && cresp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flags are registered copies of the next-state decode.
        creq_rdy_d  = (state_d == ST_IDLE);
        mreq_val_d  = (state_d == ST_RD_REQ)  || (state_d == ST_WR_REQ);
        mresp_rdy_d = (state_d == ST_RD_WAIT) || (state_d == ST_WR_WAIT);
        cresp_val_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            mreq_q      <= '0;
            cresp_q     <= '0;
            creq_rdy_q  <= 1'b1;
            mreq_val_q  <= 1'b0;
            mresp_rdy_q <= 1'b0;
            cresp_val_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            mreq_q      <= mreq_d;
            cresp_q     <= cresp_d;
            creq_rdy_q  <= creq_rdy_d;
            mreq_val_q  <= mreq_val_d;
            mresp_rdy_q <= mresp_rdy_d;
            cresp_val_q <= cresp_val_d;
        end
    end

    assign creq_rdy  = creq_rdy_q;
    assign mreq_val  = mreq_val_q;
    assign mreq_msg  = mreq_q;
    assign mresp_rdy = mresp_rdy_q;
    assign cresp_val = cresp_val_q;
    assign cresp_msg = cresp_q;

endmodule

// File: tb/tb_mem_narrow_to_wide_adapter.sv
// Directed bench: byte-addressed reference memory model, line RAM responder, per-cycle response compare.
module tb_mem_narrow_to_wide_adapter;
    import mem_narrow_to_wide_adapter_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    mem_req_4B_t   creq_msg;
    logic          creq_val, creq_rdy;
    mem_resp_4B_t  cresp_msg;
    logic          cresp_val, cresp_rdy;
    mem_req_16B_t  mreq_msg;
    logic          mreq_val, mreq_rdy;
    mem_resp_16B_t mresp_msg;
    logic          mresp_val, mresp_rdy;

    always #5 clk = ~clk;

    mem_narrow_to_wide_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .creq_msg  (creq_msg),
        .creq_val  (creq_val),
        .creq_rdy  (creq_rdy),
        .cresp_msg (cresp_msg),
        .cresp_val (cresp_val),
        .cresp_rdy (cresp_rdy),
        .mreq_msg  (mreq_msg),
        .mreq_val  (mreq_val),
        .mreq_rdy  (mreq_rdy),
        .mresp_msg (mresp_msg),
        .mresp_val (mresp_val),
        .mresp_rdy (mresp_rdy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: flat byte memory plus expected-response queue
    typedef struct {
        bit [2:0]  type_;
        bit [7:0]  opaque;
        bit [1:0]  len;
        bit [31:0] data;
    } exp_t;

    bit [7:0] rmem [bit [31:0]];
    exp_t     exp_q[$];

    function automatic bit [7:0] rbyte(input bit [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic bit [127:0] model_line(input bit [31:0] base);
        bit [127:0] l = '0;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = rbyte(base + 32'(i));
        return l;
    endfunction

    task automatic model_issue(input bit wr, input bit [31:0] addr, input bit [1:0] len,
                               input bit [31:0] data, input bit [7:0] opq);
        exp_t e;
        int   off = int'(addr % 16);
        int   n   = (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : 4;
        e.type_  = wr ? 3'd1 : 3'd0;
        e.opaque = opq;
        e.len    = len;
        e.data   = '0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 16) begin
                if (wr) rmem[addr + 32'(i)] = data[8*i +: 8];
                else    e.data[8*i +: 8] = rbyte(addr + 32'(i));
            end
        end
        exp_q.push_back(e);
    endtask

    // Line RAM responder with configurable request stall and response delay
    bit [127:0]    ram [bit [31:0]];
    int            resp_delay = 0;
    int            stall_cfg  = 0;
    int            stall_cnt  = 0;
    int            n_rd = 0, n_wr = 0;
    bit [31:0]     exp_line_addr = '0;

    function automatic bit [127:0] ram_line(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 128'h0;
    endfunction

    task automatic preload(input bit [31:0] base, input bit [127:0] l);
        ram[base] = l;
        for (int i = 0; i < 16; i++) rmem[base + 32'(i)] = l[8*i +: 8];
    endtask

    initial begin
        bit            mq, mr, pend;
        int            cnt;
        mem_req_16B_t  mm;
        mem_resp_16B_t pmsg;
        pend      = 1'b0;
        cnt       = 0;
        mreq_rdy  = 1'b1;
        mresp_val = 1'b0;
        mresp_msg = '0;
        forever begin
            @(negedge clk);
            mq = mreq_val && mreq_rdy;
            mr = mresp_val && mresp_rdy;
            mm = mreq_msg;
            @(posedge clk);
            #1;
            if (mr) mresp_val = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mresp_val = 1'b1;
                    mresp_msg = pmsg;
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (mq) begin
                chk("mreq_line_addr", 128'(mm.addr), 128'(exp_line_addr));
                pmsg        = '0;
                pmsg.type_  = mm.type_;
                pmsg.opaque = mm.opaque;
                if (mm.type_ == 3'd1) begin
                    ram[mm.addr] = mm.data;
                    n_wr++;
                end else begin
                    pmsg.data = ram_line(mm.addr);
                    n_rd++;
                end
                if (resp_delay == 0) begin
                    mresp_val = 1'b1;
                    mresp_msg = pmsg;
                end else begin
                    pend = 1'b1;
                    cnt  = resp_delay - 1;
                end
                stall_cnt = stall_cfg;
            end
            mreq_rdy = !(mreq_val && stall_cnt > 0);
            if (mreq_val && stall_cnt > 0) stall_cnt--;
        end
    end

    // Response compare on every cycle the core response is valid
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && cresp_val === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("cresp_unexpected", 128'(cresp_val), 128'(0));
                end else begin
                    chk("cresp_type",   128'(cresp_msg.type_),  128'(exp_q[0].type_));
                    chk("cresp_opaque", 128'(cresp_msg.opaque), 128'(exp_q[0].opaque));
                    chk("cresp_len",    128'(cresp_msg.len),    128'(exp_q[0].len));
                    chk("cresp_test",   128'(cresp_msg.test),   128'(0));
                    chk("cresp_data",   128'(cresp_msg.data),   128'(exp_q[0].data));
                    if (cresp_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_txn(input bit wr, input bit [31:0] addr, input bit [1:0] len,
                          input bit [31:0] data, input bit [7:0] opq, input int hold,
                          input int exp_lat, output bit [31:0] rdata);
        int t0, k, r0, w0;
        model_issue(wr, addr, len, data, opq);
        exp_line_addr   = addr & 32'hFFFF_FFF0;
        r0              = n_rd;
        w0              = n_wr;
        creq_msg        = '0;
        creq_msg.type_  = wr ? MEM_TYPE_WRITE : MEM_TYPE_READ;
        creq_msg.opaque = opq;
        creq_msg.addr   = addr;
        creq_msg.len    = len;
        creq_msg.data   = data;
        creq_val        = 1'b1;
        cresp_rdy       = (hold == 0);
        k = 0;
        while (creq_rdy !== 1'b1 && k < 100) begin step(); k++; end
        chk("creq_accept", 128'(creq_rdy), 128'(1));
        t0 = cyc;
        step();
        creq_val = 1'b0;
        k = 0;
        while (cresp_val !== 1'b1 && k < 200) begin step(); k++; end
        chk("cresp_seen", 128'(cresp_val), 128'(1));
        if (exp_lat > 0) chk("latency", 128'(cyc - t0), 128'(exp_lat));
        rdata = cresp_msg.data;
        for (int h = 0; h < hold; h++) begin
            chk("hold_creq_rdy",  128'(creq_rdy),  128'(0));
            chk("hold_mreq_val",  128'(mreq_val),  128'(0));
            chk("hold_cresp_val", 128'(cresp_val), 128'(1));
            step();
        end
        cresp_rdy = 1'b1;
        step();
        chk("post_creq_rdy",  128'(creq_rdy),  128'(1));
        chk("post_cresp_val", 128'(cresp_val), 128'(0));
        chk("line_reads",  128'(n_rd - r0), 128'(1));
        chk("line_writes", 128'(n_wr - w0), 128'(wr ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] rd;
        int        k;
        rst       = 1'b1;
        creq_val  = 1'b0;
        creq_msg  = '0;
        cresp_rdy = 1'b1;
        step();
        step();
        chk("rst_creq_rdy",  128'(creq_rdy),  128'(1));
        chk("rst_mreq_val",  128'(mreq_val),  128'(0));
        chk("rst_mresp_rdy", 128'(mresp_rdy), 128'(0));
        chk("rst_cresp_val", 128'(cresp_val), 128'(0));
        chk("rst_cresp_msg", 128'(cresp_msg), 128'(0));
        rst = 1'b0;

        preload(32'h20, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        preload(32'h30, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        preload(32'h40, 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF);
        step();

        do_txn(1'b0, 32'h24, 2'd0, 32'h0, 8'h11, 0, 3, rd);
        chk("lit_rd_24", 128'(rd), 128'(32'h8899AABB));
        do_txn(1'b1, 32'h2E, 2'd1, 32'h1234565A, 8'h22, 0, 5, rd);
        chk("lit_wr_2e", 128'(rd), 128'(0));
        do_txn(1'b0, 32'h2C, 2'd0, 32'h0, 8'h33, 0, 3, rd);
        chk("lit_rd_2c", 128'(rd), 128'(32'h005A2233));
        do_txn(1'b0, 32'h20, 2'd0, 32'h0, 8'h34, 0, 3, rd);
        chk("lit_rd_20", 128'(rd), 128'(32'hCCDDEEFF));
        do_txn(1'b0, 32'h28, 2'd0, 32'h0, 8'h35, 0, 3, rd);
        chk("lit_rd_28", 128'(rd), 128'(32'h44556677));
        do_txn(1'b0, 32'h25, 2'd1, 32'h0, 8'h36, 0, 3, rd);
        chk("lit_rd_25_b", 128'(rd), 128'(32'h000000AA));
        do_txn(1'b0, 32'h26, 2'd2, 32'h0, 8'h37, 0, 3, rd);
        chk("lit_rd_26_h", 128'(rd), 128'(32'h00008899));

        do_txn(1'b1, 32'h3F, 2'd2, 32'h0000BEEF, 8'h44, 0, 5, rd);
        chk("lit_line_30", ram_line(32'h30), 128'hEF0E0D0C_0B0A0908_07060504_03020100);
        chk("lit_line_40", ram_line(32'h40), 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF);
        do_txn(1'b0, 32'h3E, 2'd2, 32'h0, 8'h45, 0, 3, rd);
        chk("lit_rd_3e_h", 128'(rd), 128'(32'h0000EF0E));
        do_txn(1'b0, 32'h3D, 2'd0, 32'h0, 8'h46, 0, 3, rd);
        chk("lit_rd_3d_w", 128'(rd), 128'(32'h00EF0E0D));

        do_txn(1'b0, 32'h30, 2'd0, 32'h0, 8'h55, 5, 3, rd);
        chk("lit_rd_30_hold", 128'(rd), 128'(32'h03020100));

        stall_cfg  = 3;
        stall_cnt  = 3;
        resp_delay = 4;
        do_txn(1'b1, 32'h44, 2'd0, 32'hDEADBEEF, 8'h66, 0, 0, rd);
        stall_cfg  = 0;
        stall_cnt  = 0;
        resp_delay = 0;
        chk("lit_line_40_thr", ram_line(32'h40), 128'hF0F1F2F3_F4F5F6F7_DEADBEEF_FCFDFEFF);

        // Reset while waiting for the line read; no response may follow
        exp_line_addr   = 32'h20;
        creq_msg        = '0;
        creq_msg.type_  = MEM_TYPE_READ;
        creq_msg.opaque = 8'h77;
        creq_msg.addr   = 32'h20;
        creq_val        = 1'b1;
        k = 0;
        while (creq_rdy !== 1'b1 && k < 100) begin step(); k++; end
        step();
        creq_val = 1'b0;
        step();
        chk("pre_rst_mresp_rdy", 128'(mresp_rdy), 128'(1));
        rst = 1'b1;
        step();
        chk("mid_rst_creq_rdy",  128'(creq_rdy),  128'(1));
        chk("mid_rst_cresp_val", 128'(cresp_val), 128'(0));
        chk("mid_rst_mreq_val",  128'(mreq_val),  128'(0));
        rst = 1'b0;
        step();
        step();
        do_txn(1'b0, 32'h20, 2'd0, 32'h0, 8'h78, 0, 3, rd);
        chk("lit_rd_after_rst", 128'(rd), 128'(32'hCCDDEEFF));

        chk("ram_vs_model_20", ram_line(32'h20), model_line(32'h20));
        chk("ram_vs_model_30", ram_line(32'h30), model_line(32'h30));
        chk("ram_vs_model_40", ram_line(32'h40), model_line(32'h40));
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
